// File: rtl/wimax_derandomizer_if.sv
// Serial bit-stream bus around the derandomizer: upstream valid/ready/last input and
// downstream valid/ready/last output. The slave modport is the derandomizer's view.
interface wimax_derandomizer_if;
   logic in_data;
   logic in_valid;
   logic in_ready;
   logic in_last;
   logic out_data;
   logic out_valid;
   logic out_ready;
   logic out_last;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/wimax_derandomizer.sv
// Receive-side 1+x^14+x^15 derandomizer with per-burst reseed and burst length checking.
// Optional DERAND_BER_CHECK_EN adds a ones counter (ber_cnt) for all-zero PN payload tests.
module wimax_derandomizer #(
   parameter logic [14:0] SEED  = 15'b011_011_100_010_101,
   parameter int          LEN_W = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   wimax_derandomizer_if.slave   bus,
   input  logic [LEN_W-1:0]      burst_len,
   output logic                  len_err,
   output logic                  busy
`ifdef DERAND_BER_CHECK_EN
   ,
   output logic [15:0]           ber_cnt,
   output logic                  ber_cnt_vld
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [14:0]        lfsr_q, lfsr_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               out_valid_q, out_valid_d;
   logic               out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               len_err_q, len_err_d;

   logic               fb;
   logic               in_ready;
   logic               accept;
   logic [LEN_W-1:0]   len_eff;
   logic [LEN_W:0]     cnt_inc;
   logic               limit_hit;
   logic               burst_end;
   logic               out_bit;

`ifdef DERAND_BER_CHECK_EN
   logic [15:0]        ber_cnt_q, ber_cnt_d;
   logic               ber_vld_q, ber_vld_d;
`endif

   // The first beat of a burst is judged against the live burst_len, later beats against the latched copy.
   always_comb begin
      fb        = lfsr_q[1] ^ lfsr_q[0];
      out_bit   = bus.in_data ^ fb;
      in_ready  = !out_valid_q || bus.out_ready;
      accept    = bus.in_valid && in_ready;
      len_eff   = (state_q == IDLE) ? burst_len : len_q;
      cnt_inc   = (state_q == IDLE) ? (LEN_W+1)'(1) : ({1'b0, cnt_q} + (LEN_W+1)'(1));
      limit_hit = (len_eff != '0) && (cnt_inc == {1'b0, len_eff});
      burst_end = bus.in_last || limit_hit;

      state_d     = state_q;
      lfsr_d      = lfsr_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      len_err_d   = 1'b0;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = out_bit;
         out_last_d  = burst_end;
         len_err_d   = (len_eff != '0) &&
                       ((bus.in_last && (cnt_inc < {1'b0, len_eff})) ||
                        (!bus.in_last && limit_hit));
         if (state_q == IDLE) begin
            len_d = burst_len;
         end
         if (burst_end) begin
            lfsr_d  = SEED;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            lfsr_d  = {fb, lfsr_q[14:1]};
            // Unlimited bursts pin the counter at all-ones instead of wrapping.
            cnt_d   = cnt_inc[LEN_W] ? cnt_q : cnt_inc[LEN_W-1:0];
            state_d = RUN;
         end
      end
   end

`ifdef DERAND_BER_CHECK_EN
   always_comb begin
      ber_cnt_d = ber_cnt_q;
      ber_vld_d = accept && burst_end;
      if (accept && out_bit && (ber_cnt_q != 16'hFFFF)) begin
         ber_cnt_d = ber_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ber_cnt_q <= '0;
         ber_vld_q <= 1'b0;
      end else begin
         ber_cnt_q <= ber_cnt_d;
         ber_vld_q <= ber_vld_d;
      end
   end

   assign ber_cnt     = ber_cnt_q;
   assign ber_cnt_vld = ber_vld_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED;
         cnt_q       <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
         out_last_q  <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         len_err_q   <= len_err_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign len_err       = len_err_q;
   assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_wimax_derandomizer.sv
// Directed and randomized bench for wimax_derandomizer; expected output comes from a
// keystream table built from the x^15+x^14+1 recurrence and a burst-level reference model.
module tb_wimax_derandomizer;

   localparam logic [14:0] SEED  = 15'b011_011_100_010_101;
   localparam int          LEN_W = 11;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [LEN_W-1:0] burst_len = '0;
   logic             len_err;
   logic             busy;

   wimax_derandomizer_if bus ();

   wimax_derandomizer #(.SEED(SEED), .LEN_W(LEN_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .burst_len (burst_len),
      .len_err   (len_err),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   int   n_vec  = 0;
   int   n_miss = 0;

   logic ks [0:4095];

   // Burst-level reference state.
   logic m_valid, m_data, m_last, m_err;
   int   m_pos, m_len, m_idx;

   logic [7:0]  got8;
   logic        payload [0:99];
   logic        recovered [0:99];
   int          nrec;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelClear();
      m_valid = 1'b0; m_data = 1'b0; m_last = 1'b0; m_err = 1'b0;
      m_pos = 0; m_len = 0; m_idx = 0;
   endtask

   // One clock: drive at the falling edge, predict, then compare at the next falling edge.
   task automatic applyStimulus(input logic v, input logic d, input logic l, input int bl, input logic rdy);
      logic acc, lim, fin;
      int   len, pos;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = rdy;
      burst_len     = bl[LEN_W-1:0];
      #1;
      checkOutput("in_ready", {15'd0, bus.in_ready}, {15'd0, (!m_valid || rdy)});
      acc = v && (!m_valid || rdy);
      if (acc) begin
         len = (m_pos == 0) ? bl : m_len;
         pos = m_pos + 1;
         lim = (len != 0) && (pos == len);
         fin = l || lim;
         m_err   = (len != 0) && ((l && pos < len) || (!l && pos == len));
         m_valid = 1'b1;
         m_data  = d ^ ks[m_idx];
         m_last  = fin;
         if (fin) begin
            m_pos = 0; m_idx = 0;
         end else begin
            m_pos = pos; m_len = len; m_idx = m_idx + 1;
         end
      end else begin
         m_err = 1'b0;
         if (rdy) m_valid = 1'b0;
      end
      @(negedge clock);
      checkOutput("out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
      if (m_valid) begin
         checkOutput("out_data", {15'd0, bus.out_data}, {15'd0, m_data});
         checkOutput("out_last", {15'd0, bus.out_last}, {15'd0, m_last});
      end
      checkOutput("len_err", {15'd0, len_err}, {15'd0, m_err});
      checkOutput("busy", {15'd0, busy}, {15'd0, (m_pos != 0)});
   endtask

   task automatic doReset(input logic v);
      bus.in_valid  = v;
      bus.in_data   = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      modelClear();
      checkOutput("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
      checkOutput("rst_out_data", {15'd0, bus.out_data}, 16'd0);
      checkOutput("rst_out_last", {15'd0, bus.out_last}, 16'd0);
      checkOutput("rst_len_err", {15'd0, len_err}, 16'd0);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
   endtask

   initial begin
      logic s [0:4110];
      for (int i = 0; i < 15; i++) s[i] = SEED[i];
      for (int i = 0; i < 4096; i++) s[i+15] = s[i] ^ s[i+1];
      for (int i = 0; i < 4096; i++) ks[i] = s[i] ^ s[i+1];

      bus.in_valid = 1'b0; bus.in_data = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
      modelClear();
      @(negedge clock);
      doReset(1'b0);

      $display("[TB] zero burst of 8");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, (i == 7), 8, 1'b1);
         got8[i] = bus.out_data;
      end
      checkOutput("seed_sequence", {8'd0, got8}, 16'h009F);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

      $display("[TB] 100-bit randomized payload");
      nrec = 0;
      for (int i = 0; i < 100; i++) payload[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, payload[i] ^ ks[i], (i == 99), 100, 1'b1);
         if (bus.out_valid) begin
            recovered[nrec] = bus.out_data;
            nrec++;
         end
      end
      checkOutput("payload_count", nrec[15:0], 16'd100);
      for (int i = 0; i < 100; i++) begin
         if (recovered[i] !== payload[i]) begin
            checkOutput("payload_bit", {15'd0, recovered[i]}, {15'd0, payload[i]});
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

      $display("[TB] backpressure mid-burst");
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), (i == 13), 0,
                       !(i >= 4 && i < 9));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

      $display("[TB] short burst then restart");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, (i == 9), 16, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

      $display("[TB] long bursts with burst_len 4");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 4, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1);

      $display("[TB] single-bit bursts");
      applyStimulus(1'b1, 1'b1, 1'b1, 0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 3, 1'b1);

      $display("[TB] reset mid-burst");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1);
      doReset(1'b1);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, (i == 7), 0, 1'b1);
         got8[i] = bus.out_data;
      end
      checkOutput("reseed_sequence", {8'd0, got8}, 16'h009F);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         int bl_tab [5] = '{0, 1, 3, 5, 7};
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 9) == 0, bl_tab[$urandom_range(0, 4)],
                       $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
